// File: rtl/shooter_obj_ctrl_pkg.sv
// Shared types and helpers for the shooter object controller (player paddle + bullet pool).
package shooter_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [3:0] KEY_UP   = 4'h5;
    localparam logic [3:0] KEY_DOWN = 4'h0;
    localparam logic [3:0] KEY_FIRE = 4'hA;

    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
    } slot_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_UP,
        MV_DOWN
    } move_t;

    // Half-open rectangle test; the one extra bit keeps x+w from wrapping.
    function automatic logic in_rect(input coord_t px, input coord_t py,
                                     input coord_t x, input coord_t y,
                                     input coord_t w, input coord_t h);
        return ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < ({1'b0, x} + {1'b0, w})) &&
               ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} < ({1'b0, y} + {1'b0, h}));
    endfunction

endpackage

// File: rtl/shooter_obj_ctrl_if.sv
// Keypad, pixel and status signals between the game controller and its neighbours.
interface shooter_obj_ctrl_if #(
    parameter int NUM_BULLETS = 4
);
    import shooter_pkg::*;

    logic [3:0]             key_code;
    logic                   key_flag;
    coord_t                 pixel_x;
    coord_t                 pixel_y;
    logic [11:0]            rgb_player;
    logic [11:0]            rgb_bullet;
    logic [11:0]            rgb_out;
    coord_t                 player_y;
    logic [NUM_BULLETS-1:0] bul_active;
    logic                   fire_drop;

    modport master (
        output key_code, key_flag, pixel_x, pixel_y, rgb_player, rgb_bullet,
        input  rgb_out, player_y, bul_active, fire_drop
    );

    modport slave (
        input  key_code, key_flag, pixel_x, pixel_y, rgb_player, rgb_bullet,
        output rgb_out, player_y, bul_active, fire_drop
    );

endinterface

// File: rtl/shooter_obj_ctrl_bullet_slot.sv
// One bullet slot: spawn, per-tick motion, exit at the right edge, and pixel hit test.
module bullet_slot
    import shooter_pkg::*;
#(
    parameter int BUL_VEL = 4,
    parameter int BUL_W   = 5,
    parameter int BUL_H   = 8,
    parameter int X_MAX   = 640
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   spawn,
    input  logic   tick,
    input  coord_t spawn_x,
    input  coord_t spawn_y,
    input  coord_t px,
    input  coord_t py,
    output logic   active,
    output logic   hit
);

    localparam logic [COORD_W:0] EXIT_ADD = (COORD_W+1)'(BUL_VEL + BUL_W);
    localparam logic [COORD_W:0] X_LIMIT  = (COORD_W+1)'(X_MAX);

    slot_t slot_q;
    logic  exits;

    assign exits = ({1'b0, slot_q.x} + EXIT_ADD) > X_LIMIT;

    // Spawn wins over motion, so a bullet fired on a tick edge stays put that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q.active <= 1'b0;
        end else if (spawn) begin
            slot_q.active <= 1'b1;
            slot_q.x      <= spawn_x;
            slot_q.y      <= spawn_y;
        end else if (tick && slot_q.active) begin
            if (exits) begin
                slot_q.active <= 1'b0;
            end else begin
                slot_q.x <= slot_q.x + coord_t'(BUL_VEL);
            end
        end
    end

    assign active = slot_q.active;
    assign hit    = slot_q.active &&
                    in_rect(px, py, slot_q.x, slot_q.y, coord_t'(BUL_W), coord_t'(BUL_H));

endmodule

// File: rtl/shooter_obj_ctrl.sv
// Player paddle and bullet-pool controller for the 640x480 VGA path.
// Optional build macro HOLD_REPEAT_EN: holding UP/DOWN repeats the move on every tick.
module shooter_obj_ctrl
    import shooter_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int TICK_DIV    = 50000,
    parameter int PLR_VEL     = 2,
    parameter int BUL_VEL     = 4,
    parameter int PLR_W       = 50,
    parameter int PLR_H       = 100,
    parameter int BUL_W       = 5,
    parameter int BUL_H       = 8,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480,
    parameter int Y_MARGIN    = 50,
    parameter int PLR_X0      = 100,
    parameter int PLR_Y0      = 100
) (
    input logic               clk,
    input logic               reset,
    shooter_obj_ctrl_if.slave bus
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam coord_t SPAWN_X   = coord_t'(PLR_X0 + PLR_W);
    localparam coord_t SPAWN_DY  = coord_t'(PLR_H / 2 - BUL_H / 2);
    localparam coord_t Y_UP_MIN  = coord_t'(Y_MARGIN + PLR_VEL);
    localparam coord_t Y_TOP     = coord_t'(Y_MARGIN);
    localparam coord_t Y_BOT     = coord_t'(Y_MAX - PLR_H);
    localparam logic [COORD_W:0] Y_BOT_W = (COORD_W+1)'(Y_MAX - PLR_H);

    logic key_sync_p0, key_sync_p1, key_sync_p2;
    logic press_evt;
    logic [CNT_W-1:0] tick_cnt;
    logic tick;
    move_t mv_q, mv_d;
    logic hold_up, hold_down, hold_move;
    logic step_up, step_down;
    coord_t plr_y_q;
    logic fire_req, pool_full;
    logic [NUM_BULLETS-1:0] active_mask, free_mask, spawn_vec, hit_vec;
    logic [11:0] rgb_p0;
    logic fire_drop_p0;

    // Stage boundary: key_flag synchroniser and rising-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_p0 <= 1'b0;
            key_sync_p1 <= 1'b0;
            key_sync_p2 <= 1'b0;
        end else begin
            key_sync_p0 <= bus.key_flag;
            key_sync_p1 <= key_sync_p0;
            key_sync_p2 <= key_sync_p1;
        end
    end

    assign press_evt = key_sync_p1 && !key_sync_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

`ifdef HOLD_REPEAT_EN
    assign hold_up   = key_sync_p1 && (bus.key_code == KEY_UP);
    assign hold_down = key_sync_p1 && (bus.key_code == KEY_DOWN);
`else
    assign hold_up   = 1'b0;
    assign hold_down = 1'b0;
`endif
    assign hold_move = hold_up || hold_down;

    always_ff @(posedge clk) begin
        if (reset) begin
            mv_q <= MV_NONE;
        end else begin
            mv_q <= mv_d;
        end
    end

    // A press landing on a tick that already moves via auto-repeat is not queued again.
    always_comb begin
        mv_d = mv_q;
        if (tick) begin
            mv_d = MV_NONE;
        end
        if (press_evt && !(tick && hold_move)) begin
            if (bus.key_code == KEY_UP) begin
                mv_d = MV_UP;
            end else if (bus.key_code == KEY_DOWN) begin
                mv_d = MV_DOWN;
            end
        end
    end

    assign step_up   = tick && ((mv_q == MV_UP) || hold_up);
    assign step_down = tick && !step_up && ((mv_q == MV_DOWN) || hold_down);

    always_ff @(posedge clk) begin
        if (reset) begin
            plr_y_q <= coord_t'(PLR_Y0);
        end else if (step_up) begin
            plr_y_q <= (plr_y_q >= Y_UP_MIN) ? (plr_y_q - coord_t'(PLR_VEL)) : Y_TOP;
        end else if (step_down) begin
            plr_y_q <= (({1'b0, plr_y_q} + (COORD_W+1)'(PLR_VEL)) <= Y_BOT_W) ?
                       (plr_y_q + coord_t'(PLR_VEL)) : Y_BOT;
        end
    end

    // Lowest free slot via two's-complement isolate; only slots free this cycle qualify.
    assign fire_req  = press_evt && (bus.key_code == KEY_FIRE);
    assign free_mask = ~active_mask;
    assign pool_full = &active_mask;
    assign spawn_vec = fire_req ? (free_mask & (~free_mask + 1'b1)) : '0;

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(
            .BUL_VEL (BUL_VEL),
            .BUL_W   (BUL_W),
            .BUL_H   (BUL_H),
            .X_MAX   (X_MAX)
        ) u_slot (
            .clk     (clk),
            .rst     (reset),
            .spawn   (spawn_vec[i]),
            .tick    (tick),
            .spawn_x (SPAWN_X),
            .spawn_y (plr_y_q + SPAWN_DY),
            .px      (bus.pixel_x),
            .py      (bus.pixel_y),
            .active  (active_mask[i]),
            .hit     (hit_vec[i])
        );
    end

    // Stage boundary: registered pixel colour and fire-drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_p0       <= '0;
            fire_drop_p0 <= 1'b0;
        end else begin
            fire_drop_p0 <= fire_req && pool_full;
            if (|hit_vec) begin
                rgb_p0 <= bus.rgb_bullet;
            end else if (in_rect(bus.pixel_x, bus.pixel_y, coord_t'(PLR_X0), plr_y_q,
                                 coord_t'(PLR_W), coord_t'(PLR_H))) begin
                rgb_p0 <= bus.rgb_player;
            end else begin
                rgb_p0 <= '0;
            end
        end
    end

    assign bus.rgb_out    = rgb_p0;
    assign bus.player_y   = plr_y_q;
    assign bus.bul_active = active_mask;
    assign bus.fire_drop  = fire_drop_p0;

endmodule
